// File: rtl/pwm_sel_pkg.sv
// Shared types and constants for the PWM speed selector: speed code width,
// button indices and the step decode used by the update logic.
package pwm_sel_pkg;

  localparam int SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_RUN  = 2;
  localparam int BTN_NUM  = 3;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_e;

  // Opposing presses in the same cycle cancel out.
  function automatic step_e decode_step(input logic up, input logic down);
    if (up && !down) return STEP_UP;
    if (down && !up) return STEP_DOWN;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button front end: two-flop synchroniser, stability counter that
// commits a new level after DEBOUNCE_CYCLES agreeing cycles, rising-edge press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the committed level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], btn_raw};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/pwm_speed_selector.sv
// Button-driven speed/enable control for the PWM stage.
// Build option SPEED_WRAP_EN: speed wraps 7->0 / 0->7 instead of saturating.
module pwm_speed_selector
  import pwm_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_SPEED     = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_run,
  output logic [SPEED_W-1:0] speed,
  output logic               enable,
  output logic               changed
);

  logic [BTN_NUM-1:0] btn_raw, btn_level, btn_press, btn_event;

  speed_t speed_q, speed_d;
  logic   enable_q, enable_d;
  logic   changed_q, changed_d;
  step_e  step;

  assign btn_raw = {btn_run, btn_down, btn_up};

  for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(btn_raw[gi]),
      .level  (btn_level[gi]),
      .press  (btn_press[gi])
    );
  end

  // A press is only honoured while its debounced level is still high.
  assign btn_event = btn_press & btn_level;

  always_comb begin
    step     = decode_step(btn_event[BTN_UP], btn_event[BTN_DOWN]);
    speed_d  = speed_q;
    unique case (step)
`ifdef SPEED_WRAP_EN
      STEP_UP:   speed_d = speed_q + speed_t'(1);
      STEP_DOWN: speed_d = speed_q - speed_t'(1);
`else
      STEP_UP:   if (speed_q != SPEED_MAX) speed_d = speed_q + speed_t'(1);
      STEP_DOWN: if (speed_q != '0)        speed_d = speed_q - speed_t'(1);
`endif
      default:   speed_d = speed_q;
    endcase
    enable_d  = enable_q ^ btn_event[BTN_RUN];
    changed_d = (speed_d != speed_q) || (enable_d != enable_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      speed_q   <= speed_t'(RESET_SPEED);
      enable_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      speed_q   <= speed_d;
      enable_q  <= enable_d;
      changed_q <= changed_d;
    end
  end

  assign speed   = speed_q;
  assign enable  = enable_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_pwm_speed_selector.sv
// Randomised and directed bench for pwm_speed_selector against a window-based
// reference model of debounce, press detection and speed/enable updates.
module tb_pwm_speed_selector;

  localparam int N  = 4;
  localparam int RS = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_run = 1'b0;
  logic [2:0] speed;
  logic       enable, changed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  pwm_speed_selector #(
    .DEBOUNCE_CYCLES(N),
    .RESET_SPEED    (RS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_run (btn_run),
    .speed   (speed),
    .enable  (enable),
    .changed (changed)
  );

  // Reference model state: hist[b][k] is the raw sample taken k edges ago.
  int       m_speed, m_en, m_changed;
  bit [2:0] m_db, m_pend;
  bit       hist[3][0:N];

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_speed = RS; m_en = 0; m_changed = 0;
    m_db = '0; m_pend = '0;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k <= N; k++) hist[b][k] = 1'b0;
  endtask

  // A debounced level becomes v once the synchronised value (two samples
  // behind the raw input) has equalled v for the last N edges.
  task automatic model_step();
    bit raw[3];
    int ns, ne;
    raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_run;
    ns = m_speed;
    if (m_pend[0] && !m_pend[1]) ns = m_speed + 1;
    else if (m_pend[1] && !m_pend[0]) ns = m_speed - 1;
`ifdef SPEED_WRAP_EN
    ns = (ns + 8) % 8;
`else
    if (ns > 7) ns = 7;
    if (ns < 0) ns = 0;
`endif
    ne = m_pend[2] ? 1 - m_en : m_en;
    m_changed = (ns != m_speed || ne != m_en) ? 1 : 0;
    m_speed = ns;
    m_en = ne;
    for (int b = 0; b < 3; b++) begin
      bit v, all;
      v = hist[b][1];
      all = 1'b1;
      for (int k = 1; k <= N; k++) if (hist[b][k] != v) all = 1'b0;
      m_pend[b] = 1'b0;
      if (all && v != m_db[b]) begin
        m_db[b] = v;
        m_pend[b] = v;
      end
      for (int k = N; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = raw[b];
    end
  endtask

  always @(posedge clock) if (!reset) model_step();

  task automatic tick(input bit u, input bit d, input bit r);
    btn_up = u; btn_down = d; btn_run = r;
    @(negedge clock);
    cyc++;
    check_val("speed", speed, m_speed);
    check_val("enable", enable, m_en);
    check_val("changed", changed, m_changed);
    if (m_changed != 0)
      $display("cycle %0d: update speed=%0d enable=%0d", cyc, m_speed, m_en);
  endtask

  task automatic hold(input bit u, input bit d, input bit r, input int n);
    for (int i = 0; i < n; i++) tick(u, d, r);
  endtask

  task automatic press(input bit u, input bit d, input bit r);
    hold(u, d, r, N + 4);
    hold(1'b0, 1'b0, 1'b0, N + 4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_val("rst_speed", speed, RS);
    check_val("rst_enable", enable, 0);
    check_val("rst_changed", changed, 0);
    $display("cycle %0d: reset asserted", cyc);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    check_val("init_speed", speed, RS);
    check_val("init_enable", enable, 0);
    check_val("init_changed", changed, 0);
    reset = 1'b0;

    // single long hold, then bounce rejection
    hold(1'b1, 1'b0, 1'b0, 110);
    hold(1'b0, 1'b0, 1'b0, N + 4);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 1'b0, 20);
    hold(1'b0, 1'b0, 1'b0, N + 4);

    // saturation / wrap at the top, then walk down to 3
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0);

    // simultaneous presses
    press(1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b1);
    press(1'b0, 1'b0, 1'b1);

    // run toggling with speed retention
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);

    // reset mid-count with the button still held afterwards
    hold(1'b1, 1'b0, 1'b0, 5);
    do_reset();
    hold(1'b1, 1'b0, 1'b0, 20);
    hold(1'b0, 1'b0, 1'b0, N + 4);

    // randomised segments with occasional reset
    for (int s = 0; s < 300; s++) begin
      bit u, d, r;
      int len;
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 2 * N + 2);
      if ($urandom_range(0, 39) == 0) do_reset();
      hold(u, d, r, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
